// File: rtl/game_pkg.sv
// Shared definitions for the game phase sequencer: phase encoding,
// default timing parameters, the win mask and a BCD score helper.
package game_pkg;

    // Phase encoding as seen on the game_state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } game_state_e;

    localparam int DEF_INIT_LIVES    = 3;
    localparam int DEF_INVULN_FRAMES = 120;
    localparam int DEF_OVER_FRAMES   = 60;

    // Only the dragon head is still visible: the player has won.
    localparam logic [6:0] WIN_MASK  = 7'b0000001;

    localparam logic [7:0] SCORE_MAX = 8'h99;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v == SCORE_MAX) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_down_counter.sv
// 8-bit frame counter: load at any time, otherwise counts down by one on
// each frame_end until it reaches zero. Used for hit recovery and the
// minimum game-over hold.
module frame_down_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_end_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic [7:0] count_o,
    output logic       zero_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Load wins over the decrement; the count parks at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (frame_end_i && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == 8'd0);

endmodule

// File: rtl/game_phase_sequencer.sv
// Frame-synchronous game controller: phase FSM, lives, invulnerability
// window and entity freeze. Every phase decision is taken on frame_end so a
// frame never renders with half-updated state.
// Optional feature macro: GAME_SCORE_EN enables the BCD sword-hit score;
// without it score is tied to zero and sword_hit is ignored.
module game_phase_sequencer
    import game_pkg::*;
#(
    parameter int INIT_LIVES    = DEF_INIT_LIVES,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int OVER_FRAMES   = DEF_OVER_FRAMES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_end,
    input  logic       start_btn,
    input  logic       player_hit,
    input  logic       sword_hit,
    input  logic [6:0] dragon_segments,
    output logic [1:0] game_state,
    output logic [1:0] lives,
    output logic       logic_en,
    output logic       logic_reset,
    output logic       damage_flash,
    output logic       won,
    output logic [7:0] score
);

    localparam logic [1:0] LIVES_INIT  = 2'(INIT_LIVES);
    localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES);
    localparam logic [7:0] OVER_LOAD   = 8'(OVER_FRAMES);

    game_state_e state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic        logic_en_q, logic_en_d;
    logic        logic_reset_q, logic_reset_d;
    logic        damage_flash_q, damage_flash_d;
    logic        won_q, won_d;
    logic        hit_q, hit_d;
    logic        start_q, start_d;

    logic        start_edge;
    logic        win;
    logic        hit_seen;
    logic        new_game;
    logic        cnt_load;
    logic [7:0]  cnt_load_val;
    logic [7:0]  cnt_count;
    logic        cnt_zero;
    logic        cnt_last;

    // A hit in the frame_end cycle itself still belongs to the closing frame.
    assign hit_seen   = hit_q | player_hit;
    assign hit_d      = frame_end ? 1'b0 : hit_seen;
    // The button is only looked at on frame boundaries; holding never retriggers.
    assign start_d    = frame_end ? start_btn : start_q;
    assign start_edge = frame_end & start_btn & ~start_q;
    assign win        = (dragon_segments == WIN_MASK);
    // Recovery ends on the frame_end that brings the counter down to zero.
    assign cnt_last   = (cnt_count == 8'd1);
    assign new_game   = start_edge &
                        ((state_q == ST_IDLE) | ((state_q == ST_OVER) & cnt_zero));

    // State, latches and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            lives_q        <= LIVES_INIT;
            logic_en_q     <= 1'b0;
            logic_reset_q  <= 1'b0;
            damage_flash_q <= 1'b0;
            won_q          <= 1'b0;
            hit_q          <= 1'b0;
            start_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            logic_en_q     <= logic_en_d;
            logic_reset_q  <= logic_reset_d;
            damage_flash_q <= damage_flash_d;
            won_q          <= won_d;
            hit_q          <= hit_d;
            start_q        <= start_d;
        end
    end

    // Next phase; nothing moves except on frame_end.
    always_comb begin
        state_d = state_q;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: if (new_game) state_d = ST_PLAY;
                ST_PLAY: begin
                    if (win) begin
                        state_d = ST_OVER;
                    end else if (hit_seen) begin
                        state_d = (lives_q <= 2'd1) ? ST_OVER : ST_HIT;
                    end
                end
                ST_HIT: begin
                    if (win) begin
                        state_d = ST_OVER;
                    end else if (cnt_last) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_OVER: if (new_game) state_d = ST_PLAY;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output and counter control derived from the current and next phase.
    always_comb begin
        lives_d       = lives_q;
        won_d         = won_q;
        logic_reset_d = 1'b0;
        cnt_load      = 1'b0;
        cnt_load_val  = 8'd0;
        if (new_game) begin
            lives_d       = LIVES_INIT;
            won_d         = 1'b0;
            logic_reset_d = 1'b1;
        end
        if (frame_end && (state_q == ST_PLAY) && !win && hit_seen && (lives_q != 2'd0)) begin
            lives_d = lives_q - 2'd1;
        end
        if ((state_d == ST_OVER) && (state_q != ST_OVER)) begin
            cnt_load     = 1'b1;
            cnt_load_val = OVER_LOAD;
            won_d        = win;
        end
        if ((state_d == ST_HIT) && (state_q != ST_HIT)) begin
            cnt_load     = 1'b1;
            cnt_load_val = INVULN_LOAD;
        end
        logic_en_d     = (state_d == ST_PLAY) || (state_d == ST_HIT);
        damage_flash_d = (state_d == ST_HIT);
    end

    frame_down_counter u_frame_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_end_i (frame_end),
        .load_i      (cnt_load),
        .load_val_i  (cnt_load_val),
        .count_o     (cnt_count),
        .zero_o      (cnt_zero)
    );

    assign game_state   = state_q;
    assign lives        = lives_q;
    assign logic_en     = logic_en_q;
    assign logic_reset  = logic_reset_q;
    assign damage_flash = damage_flash_q;
    assign won          = won_q;

`ifdef GAME_SCORE_EN
    logic       sword_q;
    logic [7:0] score_q, score_d;

    // Count rising edges of the sword collision while the dragon can be hit.
    always_comb begin
        score_d = score_q;
        if (new_game) begin
            score_d = 8'h00;
        end else if (sword_hit && !sword_q && ((state_q == ST_PLAY) || (state_q == ST_HIT))) begin
            score_d = bcd_inc_sat(score_q);
        end
    end

    // Score and sword edge-detect registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sword_q <= 1'b0;
            score_q <= 8'h00;
        end else begin
            sword_q <= sword_hit;
            score_q <= score_d;
        end
    end

    assign score = score_q;
`else
    logic unused_sword;
    assign unused_sword = sword_hit;
    assign score        = 8'h00;
`endif

endmodule
